bnn_conv2d_stream: RTL



---
 rtl/bnn_pkg.sv | 14 +
 rtl/bnn_window_dot.sv | 24 ++
 rtl/bnn_conv2d_stream.sv | 114 +++++++++++
 3 files changed

// File: rtl/bnn_pkg.sv
// Shared types and helpers for the binary neural network datapath.
package bnn_pkg;

  typedef enum logic {ACCUM = 1'b0, OUTPUT = 1'b1} conv_state_e;

  // Sign encoding: a set bit means +1, a clear bit means -1.
  localparam logic BIT_POS = 1'b1;

  // Signed accumulator width holding +/- ic*k*k.
  function automatic int acc_width(input int ic, input int k);
    return $clog2(ic * k * k + 1) + 1;
  endfunction

endpackage

// File: rtl/bnn_window_dot.sv
// Combinational XNOR-popcount dot product of one KxK window against the kernel.
module bnn_window_dot
  import bnn_pkg::*;
#(
  parameter int K     = 3,
  parameter int ACC_W = 7
) (
  input  logic [K*K-1:0]         i_win,
  input  logic [K*K-1:0]         i_wts,
  output logic signed [ACC_W-1:0] o_dot
);

  int w_pc;

  // Each agreeing tap contributes +1, each disagreeing tap -1: dot = 2*matches - K*K.
  always_comb begin
    w_pc = 0;
    for (int i = 0; i < K * K; i++) begin
      if ((i_win[i] == BIT_POS) == (i_wts[i] == BIT_POS)) w_pc = w_pc + 1;
    end
    o_dot = ACC_W'(2 * w_pc - K * K);
  end

endmodule

// File: rtl/bnn_conv2d_stream.sv
// Streaming binary 2D convolution: accumulates IC channel beats per output map, then thresholds.
module bnn_conv2d_stream
  import bnn_pkg::*;
#(
  parameter int KERNEL_SIZE  = 3,
  parameter int STRIDE       = 1,
  parameter int IC           = 4,
  parameter int IMG_IN_SIZE  = 30,
  parameter int IMG_OUT_SIZE = (IMG_IN_SIZE - KERNEL_SIZE) / STRIDE + 1,
  parameter int ACC_W        = acc_width(IC, KERNEL_SIZE),
  parameter int CH_W         = (IC > 1) ? $clog2(IC) : 1
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [IMG_IN_SIZE*IMG_IN_SIZE-1:0] img_in,
  input  logic [KERNEL_SIZE*KERNEL_SIZE-1:0] weights,
  input  logic signed [ACC_W-1:0]          threshold,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [IMG_OUT_SIZE*IMG_OUT_SIZE-1:0] img_out,
  output logic [CH_W-1:0]                  ch_idx
);

  localparam int K    = KERNEL_SIZE;
  localparam int NPIX = IMG_OUT_SIZE * IMG_OUT_SIZE;

  if (((IMG_IN_SIZE - KERNEL_SIZE) % STRIDE) != 0) begin : g_bad_stride
    $error("bnn_conv2d_stream: (IMG_IN_SIZE-KERNEL_SIZE) not divisible by STRIDE");
  end

  conv_state_e             r_state;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic [NPIX-1:0]         r_img_out;
  logic [CH_W-1:0]         r_ch;
  logic signed [ACC_W-1:0] r_acc [NPIX];

  logic signed [ACC_W-1:0] w_dot [NPIX];
  logic signed [ACC_W-1:0] w_sum [NPIX];
  logic [NPIX-1:0]         w_bit;
  logic                    w_beat;
  logic                    w_last;

  for (genvar gr = 0; gr < IMG_OUT_SIZE; gr++) begin : g_row
    for (genvar gc = 0; gc < IMG_OUT_SIZE; gc++) begin : g_col
      localparam int P = gr * IMG_OUT_SIZE + gc;
      logic [K*K-1:0] w_win;
      for (genvar gi = 0; gi < K; gi++) begin : g_wi
        for (genvar gj = 0; gj < K; gj++) begin : g_wj
          assign w_win[gi*K+gj] = img_in[(gr*STRIDE+gi)*IMG_IN_SIZE + gc*STRIDE + gj];
        end
      end
      bnn_window_dot #(.K(K), .ACC_W(ACC_W)) u_dot (
        .i_win (w_win),
        .i_wts (weights),
        .o_dot (w_dot[P])
      );
      // |acc| never exceeds IC*K*K, so the ACC_W-wide add cannot wrap.
      assign w_sum[P] = r_acc[P] + w_dot[P];
      assign w_bit[P] = (w_sum[P] >= threshold);
    end
  end

  assign w_beat = in_valid && r_in_ready;
  assign w_last = (r_ch == CH_W'(IC - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= ACCUM;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_img_out   <= '0;
      r_ch        <= '0;
      for (int p = 0; p < NPIX; p++) r_acc[p] <= '0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_beat) begin
            for (int p = 0; p < NPIX; p++) r_acc[p] <= w_sum[p];
            if (w_last) begin
              r_ch        <= '0;
              r_img_out   <= w_bit;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
              r_state     <= OUTPUT;
            end else begin
              r_ch <= r_ch + 1'b1;
            end
          end else if (!r_in_ready) begin
            // Bubble cycle right after the output handshake.
            r_in_ready <= 1'b1;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_ch        <= '0;
            r_state     <= ACCUM;
            for (int p = 0; p < NPIX; p++) r_acc[p] <= '0;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign img_out   = r_img_out;
  assign ch_idx    = r_ch;

endmodule
